// File: rtl/scarv_cop_common.sv
// -----------------------------------------------------------------------------
// scarv_cop_common
//   Definitions shared by the SCARV coprocessor dispatch logic:
//     - instruction class codes and the class -> functional-unit lane mapping
//     - response codes returned to the host CPU
//     - dispatch FSM state encoding
// -----------------------------------------------------------------------------
package scarv_cop_common;

    // Number of lanes the class mapping knows about. Classes 1..9 occupy
    // lanes 0..8; class 0 and classes 10..15 have no functional unit.
    localparam int SCARV_COP_NUM_LANES = 9;

    typedef enum logic [3:0] {
        CLASS_NONE         = 4'd0,
        CLASS_PACKED_ARITH = 4'd1,
        CLASS_TWIDDLE      = 4'd2,
        CLASS_LOADSTORE    = 4'd3,
        CLASS_RANDOM       = 4'd4,
        CLASS_MOVE         = 4'd5,
        CLASS_MP           = 4'd6,
        CLASS_BITWISE      = 4'd7,
        CLASS_AES          = 4'd8,
        CLASS_SHA3         = 4'd9
    } cop_class_t;

    localparam logic [1:0] SCARV_COP_RSP_OK      = 2'b00;
    localparam logic [1:0] SCARV_COP_RSP_ILLEGAL = 2'b01;
    localparam logic [1:0] SCARV_COP_RSP_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESP   = 3'd4
    } dispatch_state_t;

    // One-hot lane select for a decoder class; all-zero means "no unit".
    function automatic logic [SCARV_COP_NUM_LANES-1:0] class_onehot(input logic [3:0] cls);
        logic [SCARV_COP_NUM_LANES-1:0] lanes;
        lanes = '0;
        for (int i = 0; i < SCARV_COP_NUM_LANES; i++) begin
            if (cls == 4'(i + 1)) lanes[i] = 1'b1;
        end
        return lanes;
    endfunction

endpackage

// File: rtl/scarv_cop_dispatch_timer.sv
// -----------------------------------------------------------------------------
// scarv_cop_dispatch_timer
//   8-bit saturating cycle counter used to bound the WAIT state.
//   Ports:
//     g_clk, g_reset : clock, synchronous active-high reset
//     clear          : zero the counter (takes priority over enable)
//     enable         : count the current cycle
//     expired        : the count including the current cycle equals TIMEOUT
// -----------------------------------------------------------------------------
module scarv_cop_dispatch_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic g_clk,
    input  logic g_reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count_q;
    logic [7:0] count_d;
    logic [7:0] count_inc;

    // NOTE: combinational blocks assign every output a default first so no
    // path through them leaves a value unassigned (which would infer a latch).
    always_comb begin
        count_inc = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
        count_d   = count_q;
        if (clear) begin
            count_d = 8'd0;
        end else if (enable) begin
            count_d = count_inc;
        end
        // count_inc is the number of enabled cycles including this one, so
        // expiry fires on the TIMEOUT-th enabled cycle after a clear.
        expired = enable && !clear && (count_inc == 8'(TIMEOUT));
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking assignments are reserved for always_comb.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/scarv_cop_dispatch.sv
// -----------------------------------------------------------------------------
// scarv_cop_dispatch
//   Instruction dispatch controller for the SCARV crypto coprocessor.
//   Accepts one instruction from the CPU, holds it for the decoder, pulses the
//   start strobe of the selected functional unit, waits for completion or a
//   timeout and returns a response with an optional GPR writeback.
//   Ports:
//     g_clk, g_reset          : clock, synchronous active-high reset
//     cpu_insn_req/ack/enc    : instruction handshake and encoding
//     cpu_rs1                 : rs1 operand captured with the encoding
//     cpu_rsp_*               : response channel (valid/ready, code, writeback)
//     id_encoded              : registered encoding feeding the decoder
//     id_exception/class/rd   : decoder results
//     op_rs1                  : registered rs1 feeding the functional units
//     fu_ivalid / fu_idone    : per-unit start pulse and completion
//     fu_gpr_wen / wdata      : completing unit's writeback request
//     busy                    : controller is not idle
// -----------------------------------------------------------------------------
module scarv_cop_dispatch
    import scarv_cop_common::*;
#(
    parameter int NUM_FU  = 9,
    parameter int TIMEOUT = 255
) (
    input  logic              g_clk,
    input  logic              g_reset,
    input  logic              cpu_insn_req,
    output logic              cpu_insn_ack,
    input  logic [31:0]       cpu_insn_enc,
    input  logic [31:0]       cpu_rs1,
    output logic              cpu_rsp_valid,
    input  logic              cpu_rsp_ready,
    output logic [1:0]        cpu_rsp_code,
    output logic              cpu_rsp_wen,
    output logic [4:0]        cpu_rsp_rd,
    output logic [31:0]       cpu_rsp_wdata,
    output logic [31:0]       id_encoded,
    input  logic              id_exception,
    input  logic [3:0]        id_class,
    input  logic [4:0]        id_rd,
    output logic [31:0]       op_rs1,
    output logic [NUM_FU-1:0] fu_ivalid,
    input  logic [NUM_FU-1:0] fu_idone,
    input  logic              fu_gpr_wen,
    input  logic [31:0]       fu_gpr_wdata,
    output logic              busy
);

    dispatch_state_t state_q, state_d;
    logic [31:0]       id_encoded_q, id_encoded_d;
    logic [31:0]       op_rs1_q, op_rs1_d;
    logic [NUM_FU-1:0] sel_q, sel_d;
    logic [4:0]        rd_q, rd_d;
    logic [1:0]        rsp_code_q, rsp_code_d;
    logic              rsp_wen_q, rsp_wen_d;
    logic [31:0]       rsp_wdata_q, rsp_wdata_d;

    logic [SCARV_COP_NUM_LANES-1:0] class_vec;
    logic [NUM_FU-1:0]              class_sel;
    logic                           sel_done;
    logic                           timer_clear;
    logic                           timer_enable;
    logic                           timer_expired;

    scarv_cop_dispatch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // Lanes beyond the class map (or beyond NUM_FU) are never selected, so a
    // class without a lane yields an all-zero select.
    always_comb begin
        class_vec = class_onehot(id_class);
        class_sel = '0;
        for (int i = 0; i < NUM_FU && i < SCARV_COP_NUM_LANES; i++) begin
            class_sel[i] = class_vec[i];
        end
    end

    // Completion is only meaningful on the selected lane.
    assign sel_done = |(fu_idone & sel_q);

    always_comb begin
        state_d      = state_q;
        id_encoded_d = id_encoded_q;
        op_rs1_d     = op_rs1_q;
        sel_d        = sel_q;
        rd_d         = rd_q;
        rsp_code_d   = rsp_code_q;
        rsp_wen_d    = rsp_wen_q;
        rsp_wdata_d  = rsp_wdata_q;
        cpu_insn_ack = 1'b0;
        fu_ivalid    = '0;
        timer_clear  = 1'b0;
        timer_enable = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A request seen during reset is not acknowledged: the capture
                // would be discarded by the reset anyway.
                if (cpu_insn_req && !g_reset) begin
                    cpu_insn_ack = 1'b1;
                    id_encoded_d = cpu_insn_enc;
                    op_rs1_d     = cpu_rs1;
                    state_d      = ST_DECODE;
                end
            end

            ST_DECODE: begin
                sel_d = class_sel;
                rd_d  = id_rd;
                if (id_exception || (class_sel == '0)) begin
                    rsp_code_d  = SCARV_COP_RSP_ILLEGAL;
                    rsp_wen_d   = 1'b0;
                    rsp_wdata_d = 32'd0;
                    state_d     = ST_RESP;
                end else begin
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                fu_ivalid   = g_reset ? '0 : sel_q;
                timer_clear = 1'b1;
                if (sel_done) begin
                    rsp_code_d  = SCARV_COP_RSP_OK;
                    rsp_wen_d   = fu_gpr_wen;
                    rsp_wdata_d = fu_gpr_wdata;
                    state_d     = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                timer_enable = 1'b1;
                // Done is tested first so it wins over a same-cycle expiry.
                if (sel_done) begin
                    rsp_code_d  = SCARV_COP_RSP_OK;
                    rsp_wen_d   = fu_gpr_wen;
                    rsp_wdata_d = fu_gpr_wdata;
                    state_d     = ST_RESP;
                end else if (timer_expired) begin
                    rsp_code_d  = SCARV_COP_RSP_TIMEOUT;
                    rsp_wen_d   = 1'b0;
                    rsp_wdata_d = 32'd0;
                    state_d     = ST_RESP;
                end
            end

            ST_RESP: begin
                if (cpu_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q      <= ST_IDLE;
            id_encoded_q <= 32'd0;
            op_rs1_q     <= 32'd0;
            sel_q        <= '0;
            rd_q         <= 5'd0;
            rsp_code_q   <= SCARV_COP_RSP_OK;
            rsp_wen_q    <= 1'b0;
            rsp_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            id_encoded_q <= id_encoded_d;
            op_rs1_q     <= op_rs1_d;
            sel_q        <= sel_d;
            rd_q         <= rd_d;
            rsp_code_q   <= rsp_code_d;
            rsp_wen_q    <= rsp_wen_d;
            rsp_wdata_q  <= rsp_wdata_d;
        end
    end

    assign cpu_rsp_valid = (state_q == ST_RESP);
    assign cpu_rsp_code  = rsp_code_q;
    assign cpu_rsp_wen   = rsp_wen_q;
    assign cpu_rsp_rd    = rd_q;
    assign cpu_rsp_wdata = rsp_wdata_q;
    assign id_encoded    = id_encoded_q;
    assign op_rs1        = op_rs1_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_scarv_cop_dispatch.sv
// -----------------------------------------------------------------------------
// tb_scarv_cop_dispatch
//   Self-checking bench for scarv_cop_dispatch (TIMEOUT = 4). The bench plays
//   the CPU, the decoder and the functional units. Expected responses come from
//   a transaction-level model: which lane a class uses, whether the instruction
//   is illegal, and the cycle at which the response must appear.
// -----------------------------------------------------------------------------
module tb_scarv_cop_dispatch;
    import scarv_cop_common::*;

    localparam int NUM_FU = 9;
    localparam int TO     = 4;

    logic              g_clk = 1'b0;
    logic              g_reset;
    logic              cpu_insn_req;
    logic              cpu_insn_ack;
    logic [31:0]       cpu_insn_enc;
    logic [31:0]       cpu_rs1;
    logic              cpu_rsp_valid;
    logic              cpu_rsp_ready;
    logic [1:0]        cpu_rsp_code;
    logic              cpu_rsp_wen;
    logic [4:0]        cpu_rsp_rd;
    logic [31:0]       cpu_rsp_wdata;
    logic [31:0]       id_encoded;
    logic              id_exception;
    logic [3:0]        id_class;
    logic [4:0]        id_rd;
    logic [31:0]       op_rs1;
    logic [NUM_FU-1:0] fu_ivalid;
    logic [NUM_FU-1:0] fu_idone;
    logic              fu_gpr_wen;
    logic [31:0]       fu_gpr_wdata;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    scarv_cop_dispatch #(
        .NUM_FU  (NUM_FU),
        .TIMEOUT (TO)
    ) dut (
        .g_clk         (g_clk),
        .g_reset       (g_reset),
        .cpu_insn_req  (cpu_insn_req),
        .cpu_insn_ack  (cpu_insn_ack),
        .cpu_insn_enc  (cpu_insn_enc),
        .cpu_rs1       (cpu_rs1),
        .cpu_rsp_valid (cpu_rsp_valid),
        .cpu_rsp_ready (cpu_rsp_ready),
        .cpu_rsp_code  (cpu_rsp_code),
        .cpu_rsp_wen   (cpu_rsp_wen),
        .cpu_rsp_rd    (cpu_rsp_rd),
        .cpu_rsp_wdata (cpu_rsp_wdata),
        .id_encoded    (id_encoded),
        .id_exception  (id_exception),
        .id_class      (id_class),
        .id_rd         (id_rd),
        .op_rs1        (op_rs1),
        .fu_ivalid     (fu_ivalid),
        .fu_idone      (fu_idone),
        .fu_gpr_wen    (fu_gpr_wen),
        .fu_gpr_wdata  (fu_gpr_wdata),
        .busy          (busy)
    );

    always #5 g_clk = ~g_clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            $error("check %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One full transaction. Cycle 0 is the ack cycle; the selected unit signals
    // done in cycle 2+done_dly (0 = during ISSUE). The CPU raises ready
    // rwait (>=1) cycles after the response first appears, and keeps req high
    // while the response is pending to prove no early ack is given.
    task automatic run_insn(input string name, input int cls, input bit exc, input int done_dly,
                            input bit spur, input int rwait, input bit wen,
                            input logic [31:0] wdata, input logic [31:0] rs1);
        int          lane;
        bit          illegal;
        int          exp_lat;
        logic [1:0]  exp_code;
        bit          exp_wen;
        logic [31:0] enc;
        logic [4:0]  rd;
        int          rsp_at;
        int          pulses;
        bit          pulse_ok, busy_ok, stable_ok, ack_leak, hs_seen;
        logic [1:0]  s_code;
        logic        s_wen;
        logic [4:0]  s_rd;
        logic [31:0] s_wdata;
        bit          hs;

        lane    = (cls >= 1 && cls <= NUM_FU) ? cls - 1 : -1;
        illegal = exc || (lane < 0);
        if (illegal) begin
            exp_lat = 2; exp_code = 2'b01; exp_wen = 1'b0;
        end else if (done_dly <= TO) begin
            exp_lat = 3 + done_dly; exp_code = 2'b00; exp_wen = wen;
        end else begin
            exp_lat = TO + 3; exp_code = 2'b10; exp_wen = 1'b0;
        end
        enc = $urandom;
        rd  = 5'($urandom);

        cpu_insn_req  = 1'b1;
        cpu_insn_enc  = enc;
        cpu_rs1       = rs1;
        id_class      = 4'(cls);
        id_exception  = exc;
        id_rd         = rd;
        cpu_rsp_ready = 1'b0;
        fu_idone      = '0;
        #1;
        check({name, ".ack"}, cpu_insn_ack, 1);

        rsp_at = -1; pulses = 0; pulse_ok = 1; busy_ok = 1; stable_ok = 1;
        ack_leak = 0; hs_seen = 0;
        s_code = '0; s_wen = 0; s_rd = '0; s_wdata = '0;
        for (int c = 1; c <= TO + 40; c++) begin
            @(posedge g_clk); #1;
            cpu_insn_req = (rsp_at >= 0);
            fu_idone     = '0;
            if (lane >= 0 && c == 2 + done_dly) fu_idone[lane] = 1'b1;
            if (spur && c == 3) fu_idone[(lane < 0) ? 0 : (lane + 1) % NUM_FU] = 1'b1;
            fu_gpr_wen    = (c == 2 + done_dly) ? wen   : 1'($urandom);
            fu_gpr_wdata  = (c == 2 + done_dly) ? wdata : $urandom;
            hs            = (rsp_at >= 0) && (c >= rsp_at + rwait);
            cpu_rsp_ready = hs;
            #1;
            if (fu_ivalid != '0) begin
                pulses++;
                if (c != 2 || lane < 0 || fu_ivalid != (NUM_FU'(1) << lane)) pulse_ok = 0;
            end
            if (c == 1) begin
                check({name, ".id_encoded"}, id_encoded, enc);
                check({name, ".op_rs1"}, op_rs1, rs1);
            end
            if (busy !== 1'b1) busy_ok = 0;
            if (cpu_insn_ack !== 1'b0) ack_leak = 1;
            if (rsp_at < 0 && cpu_rsp_valid === 1'b1) begin
                rsp_at = c;
                check({name, ".latency"}, c, exp_lat);
                check({name, ".code"}, cpu_rsp_code, exp_code);
                check({name, ".wen"}, cpu_rsp_wen, exp_wen);
                check({name, ".rd"}, cpu_rsp_rd, rd);
                if (exp_code == 2'b00) check({name, ".wdata"}, cpu_rsp_wdata, wdata);
                s_code = cpu_rsp_code; s_wen = cpu_rsp_wen;
                s_rd = cpu_rsp_rd; s_wdata = cpu_rsp_wdata;
            end else if (rsp_at >= 0) begin
                if (cpu_rsp_valid !== 1'b1 || cpu_rsp_code !== s_code || cpu_rsp_wen !== s_wen ||
                    cpu_rsp_rd !== s_rd || cpu_rsp_wdata !== s_wdata) stable_ok = 0;
            end
            if (hs) begin
                hs_seen = 1;
                break;
            end
        end

        check({name, ".handshake"}, hs_seen, 1);
        check({name, ".ivalid_pulses"}, pulses, illegal ? 0 : 1);
        check({name, ".ivalid_onehot"}, pulse_ok, 1);
        check({name, ".busy_held"}, busy_ok, 1);
        check({name, ".no_early_ack"}, ack_leak, 0);
        check({name, ".rsp_stable"}, stable_ok, 1);

        @(posedge g_clk); #1;
        cpu_insn_req  = 1'b0;
        cpu_rsp_ready = 1'b0;
        fu_idone      = '0;
        #1;
        check({name, ".idle_busy"}, busy, 0);
        check({name, ".idle_valid"}, cpu_rsp_valid, 0);
    endtask

    initial begin
        g_reset       = 1'b1;
        cpu_insn_req  = 1'b0;
        cpu_insn_enc  = '0;
        cpu_rs1       = '0;
        cpu_rsp_ready = 1'b0;
        id_exception  = 1'b0;
        id_class      = '0;
        id_rd         = '0;
        fu_idone      = '0;
        fu_gpr_wen    = 1'b0;
        fu_gpr_wdata  = '0;

        // Reset state.
        repeat (2) @(posedge g_clk);
        #1;
        check("reset.busy", busy, 0);
        check("reset.rsp_valid", cpu_rsp_valid, 0);
        check("reset.ack", cpu_insn_ack, 0);
        check("reset.outputs", {cpu_rsp_code, cpu_rsp_wen, cpu_rsp_rd, cpu_rsp_wdata}, 0);
        check("reset.id_encoded", id_encoded, 0);
        check("reset.op_rs1", op_rs1, 0);
        check("reset.ivalid", fu_ivalid, 0);
        g_reset = 1'b0;
        @(posedge g_clk); #1;

        // Single-cycle unit, illegal paths, timeout with late done, backpressure,
        // spurious done, simultaneous done/expiry and the cycle after expiry.
        run_insn("single",     CLASS_MOVE,    0, 0,      0, 1, 1, 32'hDEAD_BEEF, 32'h1234_5678);
        run_insn("illegal",    CLASS_MOVE,    1, 0,      0, 1, 1, 32'h1111_1111, $urandom);
        run_insn("no_lane0",   0,             0, 1,      0, 1, 1, $urandom,      $urandom);
        run_insn("no_lane12",  12,            0, 1,      0, 2, 1, $urandom,      $urandom);
        run_insn("timeout",    CLASS_AES,     0, TO + 2, 0, 3, 1, $urandom,      $urandom);
        run_insn("after_to",   CLASS_SHA3,    0, 2,      0, 1, 1, 32'hCAFE_F00D, $urandom);
        run_insn("backpress",  CLASS_MP,      0, 1,      0, 5, 1, 32'h0BAD_CAFE, $urandom);
        run_insn("spurious",   CLASS_TWIDDLE, 0, 3,      1, 1, 1, 32'h5555_AAAA, $urandom);
        run_insn("simul_done", CLASS_PACKED_ARITH, 0, TO, 0, 1, 1, 32'h7777_0001, $urandom);
        run_insn("late_done",  CLASS_RANDOM,  0, TO + 1, 0, 2, 1, $urandom,      $urandom);
        run_insn("wen_low",    CLASS_BITWISE, 0, 0,      0, 1, 0, 32'h0000_0042, $urandom);

        // Reset while waiting on a unit that never finishes.
        cpu_insn_req = 1'b1;
        cpu_insn_enc = 32'hA5A5_0F0F;
        cpu_rs1      = 32'h0101_0101;
        id_class     = CLASS_LOADSTORE;
        id_exception = 1'b0;
        id_rd        = 5'd17;
        @(posedge g_clk); #1;
        cpu_insn_req = 1'b0;
        repeat (3) @(posedge g_clk);
        #1;
        check("rst_mid.in_wait", busy, 1);
        g_reset = 1'b1;
        @(posedge g_clk); #1;
        g_reset = 1'b0;
        #1;
        check("rst_mid.busy", busy, 0);
        check("rst_mid.rsp_valid", cpu_rsp_valid, 0);
        check("rst_mid.outputs", {cpu_rsp_code, cpu_rsp_wen, cpu_rsp_rd, cpu_rsp_wdata}, 0);
        check("rst_mid.regs", {id_encoded, op_rs1}, 0);
        check("rst_mid.ivalid", fu_ivalid, 0);
        run_insn("post_reset", CLASS_LOADSTORE, 0, 1, 0, 1, 1, 32'h600D_600D, $urandom);

        // Randomised traffic against the same model.
        for (int n = 0; n < 40; n++) begin
            run_insn("random", $urandom_range(0, 15), ($urandom_range(0, 7) == 0),
                     $urandom_range(0, TO + 3), 1'($urandom), $urandom_range(1, 3),
                     1'($urandom), $urandom, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scarv_cop_dispatch.md
# scarv_cop_dispatch

Instruction dispatch controller for the SCARV crypto coprocessor. It accepts one ISE instruction at a time from the host CPU and holds the encoding in a register that drives the instruction decoder. Using the decoder's class and exception outputs, it issues a one-cycle start pulse to exactly one functional unit, waits for that unit's completion or a timeout, and returns a response with an optional GPR writeback to the CPU.

## Interface
Parameters:
- `NUM_FU`, 9: number of functional-unit class lanes.
- `TIMEOUT`, 255: maximum cycles spent in WAIT before abandoning the instruction; range 1..255.

Ports:
- `g_clk  in  1`: clock; everything is sampled on the rising edge.
- `g_reset  in  1`: synchronous, active-high reset.
- `cpu_insn_req  in  1`: CPU presents an instruction.
- `cpu_insn_ack  out  1`: instruction accepted this cycle.
- `cpu_insn_enc  in  32`: instruction encoding.
- `cpu_rs1  in  32`: GPR rs1 operand, captured together with the encoding.
- `cpu_rsp_valid  out  1`: response available.
- `cpu_rsp_ready  in  1`: CPU consumes the response.
- `cpu_rsp_code  out  2`: response code. 00 OK, 01 ILLEGAL, 10 TIMEOUT, 11 reserved (never driven).
- `cpu_rsp_wen  out  1`: CPU must write `cpu_rsp_wdata` to GPR `cpu_rsp_rd`.
- `cpu_rsp_rd  out  5`: destination GPR.
- `cpu_rsp_wdata  out  32`: writeback data.
- `id_encoded  out  32`: registered encoding, drives the decoder.
- `id_exception  in  1`: decoder illegal-instruction flag.
- `id_class  in  4`: decoder instruction class.
- `id_rd  in  5`: decoder GPR destination field.
- `op_rs1  out  32`: registered rs1, routed to the functional units.
- `fu_ivalid  out  NUM_FU`: one-hot, one-cycle start pulse.
- `fu_idone  in  NUM_FU`: per-unit completion.
- `fu_gpr_wen  in  1`: completing unit requests a GPR write.
- `fu_gpr_wdata  in  32`: result bus, muxed externally from the completing unit.
- `busy  out  1`: high whenever the state is not IDLE.

## Operation
- State machine: IDLE → DECODE → ISSUE → WAIT → RESP → IDLE. Reset forces IDLE.
- **IDLE**
  - `cpu_insn_ack = cpu_insn_req & (state==IDLE)`; this signal is combinational.
  - On ack, capture `cpu_insn_enc` into `id_encoded` and `cpu_rs1` into `op_rs1`, then go to DECODE.
- **DECODE** (one cycle)
  - Register `sel = class_onehot(id_class)` and `id_rd`.
  - If `id_exception=1` or `id_class` maps to no lane: code ILLEGAL, go to RESP.
  - Otherwise go to ISSUE.
- **ISSUE** (one cycle)
  - `fu_ivalid = sel`.
  - Clear the counter.
  - If `fu_idone & sel` is nonzero this cycle, complete immediately (see WAIT completion) and go to RESP. Otherwise go to WAIT.
- **WAIT**
  - `fu_ivalid = 0`.
  - Completion: when `fu_idone & sel` is nonzero, capture `cpu_rsp_wen=fu_gpr_wen`, `cpu_rsp_wdata=fu_gpr_wdata` and code OK, then go to RESP.
  - Counter increments each cycle. When it equals `TIMEOUT` with no done, set code TIMEOUT with `wen=0`, and go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- **RESP**
  - `cpu_rsp_valid` is held high and all `cpu_rsp_*` outputs stay stable until `cpu_rsp_ready`.
  - On the cycle with `cpu_rsp_ready`, go to IDLE.
  - The next instruction can be acked no earlier than the cycle after the handshake.
- `cpu_rsp_wen` is forced to 0 for every non-OK code.
- `fu_idone` bits outside `sel`, and any done seen outside ISSUE/WAIT, are ignored.
- Counter width is 8 bits and saturates; it never wraps.

## Timing
- Reset values: all outputs 0, `id_encoded=0`, `op_rs1=0`, counter 0, state IDLE.
- A reset in any state returns to IDLE next cycle. Any pending response is dropped and no `fu_ivalid` is emitted.
- Cycle-level sequence, with ack in cycle 0:
  - cycle 1: DECODE.
  - cycle 2: ISSUE, `fu_ivalid` high.
  - cycle 3: earliest `cpu_rsp_valid`. This is the minimum accept-to-response latency of 3 cycles.
- ILLEGAL: `cpu_rsp_valid` is asserted in cycle 2 and `fu_ivalid` never pulses.
- TIMEOUT: `cpu_rsp_valid` is asserted `TIMEOUT+3` cycles after ack.
- `busy` is asserted from cycle 1 through the response handshake cycle inclusive.

## Structure
- Shared package/header `scarv_cop_common` holds:
  - class codes and the `class_onehot` lane mapping;
  - response-code constants `SCARV_COP_RSP_OK`, `SCARV_COP_RSP_ILLEGAL`, `SCARV_COP_RSP_TIMEOUT`;
  - FSM state encodings.
- Sub-module `scarv_cop_dispatch_timer` implements the clear/enable/saturating counter and asserts an `expired` output when the count equals `TIMEOUT`.
- The decoder is instantiated at the coprocessor top, fed by `id_encoded`.

## Test plan
- **Single-cycle unit:** valid MOVE-class encoding, rs1=0x1234_5678. The unit asserts done in the ISSUE cycle with wen=1, wdata=0xDEAD_BEEF → code 00, wen=1, wdata=0xDEAD_BEEF, rsp_valid exactly 3 cycles after ack, and `fu_ivalid` one-hot for exactly one cycle.
- **Illegal instruction:** `id_exception=1` → code 01, wen=0, `fu_ivalid` never asserted, rsp_valid 2 cycles after ack.
- **Timeout:** TIMEOUT=4 and the unit never completes → code 10, wen=0, rsp_valid 7 cycles after ack. A late done pulse after that is ignored and the next instruction decodes correctly.
- **Response backpressure:** `cpu_rsp_ready` held low for 5 cycles → `cpu_rsp_*` outputs stable throughout, `cpu_insn_ack` stays 0 even with `cpu_insn_req` high, and an ack is possible the cycle after the handshake.
- **Spurious and simultaneous done:** a non-selected `fu_idone` bit pulses during WAIT → ignored. Selected done on the same cycle the counter reaches TIMEOUT → code 00.
- **Reset mid-operation:** assert `g_reset` in WAIT → next cycle `busy=0`, all outputs 0, and a following instruction completes normally.
